// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional macro MULTICYCLE_ADDI_EN adds ADDI support through states ADDI_EXEC and ADDI_WB.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] OpALU,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_out
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADDR   = 4'd2,
        MEMREAD   = 4'd3,
        MEMWB     = 4'd4,
        MEMWRITE  = 4'd5,
        EXECUTE   = 4'd6,
        RCOMPLETE = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Outputs are decoded only outside reset so no strobe leaks while rst is held.
    always_comb begin
        state_next  = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        OpALU       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        state_out   = 4'd0;
        if (!rst) begin
            state_out = state_reg;
            case (state_reg)
                FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'b01;
                    IRWrite    = mem_ready;
                    PCWrite    = mem_ready;
                    state_next = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_next = MEMADDR;
                        OP_RTYPE:     state_next = EXECUTE;
                        OP_BEQ:       state_next = BRANCH;
                        OP_J:         state_next = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:      state_next = ADDI_EXEC;
`endif
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                            state_next = FETCH;
                        end
                    endcase
                end
                MEMADDR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    state_next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    MemRead    = 1'b1;
                    IorD       = 1'b1;
                    state_next = mem_ready ? MEMWB : MEMREAD;
                end
                MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                    state_next = mem_ready ? FETCH : MEMWRITE;
                end
                EXECUTE: begin
                    ALUSrcA    = 1'b1;
                    OpALU      = 2'b10;
                    state_next = RCOMPLETE;
                end
                RCOMPLETE: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    OpALU       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
`ifdef MULTICYCLE_ADDI_EN
                ADDI_EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    state_next = ADDI_WB;
                end
                ADDI_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                // Unused codes fall back to FETCH with every output low.
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction cycle-sequence model plus literal pins.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, OpALU, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state_out;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .OpALU(OpALU),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef logic [17:0] ovec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int st_q[$];
    logic mr_q[$];
    logic exp_valid = 1'b0;
    int   exp_state = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_at = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ovec_t dut_vec();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSource, instr_done, illegal_op};
    endfunction

    function automatic logic addi_en();
`ifdef MULTICYCLE_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010) || (addi_en() && op == 6'b001000);
    endfunction

    // Required control word for a phase of an instruction, straight from the control table.
    function automatic ovec_t exp_out(input int st, input logic mr, input logic [5:0] op);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        logic rdst = 0, rw = 0, srca = 0, done = 0, ill = 0;
        logic [1:0] srcb = 0, opalu = 0, pcsrc = 0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; if (!legal(op)) begin ill = 1; done = 1; end end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mwr = 1; iord = 1; done = mr; end
            6:  begin srca = 1; opalu = 2'b10; end
            7:  begin rw = 1; rdst = 1; done = 1; end
            8:  begin srca = 1; opalu = 2'b01; pcwc = 1; pcsrc = 2'b01; done = 1; end
            9:  begin pcw = 1; pcsrc = 2'b10; done = 1; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, opalu, pcsrc, done, ill};
    endfunction

    // Builds the expected phase list and the mem_ready pattern to apply.
    task automatic build(input logic [5:0] op, input int fstall, input int mstall);
        st_q.delete();
        mr_q.delete();
        for (int i = 0; i < fstall; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'b0);
        if (op == 6'b100011) begin
            st_q.push_back(2); mr_q.push_back(1'b0);
            for (int i = 0; i < mstall; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
            st_q.push_back(3); mr_q.push_back(1'b1);
            st_q.push_back(4); mr_q.push_back(1'b0);
        end else if (op == 6'b101011) begin
            st_q.push_back(2); mr_q.push_back(1'b0);
            for (int i = 0; i < mstall; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
            st_q.push_back(5); mr_q.push_back(1'b1);
        end else if (op == 6'b000000) begin
            st_q.push_back(6); mr_q.push_back(1'b0);
            st_q.push_back(7); mr_q.push_back(1'b0);
        end else if (op == 6'b000100) begin
            st_q.push_back(8); mr_q.push_back(1'b0);
        end else if (op == 6'b000010) begin
            st_q.push_back(9); mr_q.push_back(1'b0);
        end else if (addi_en() && op == 6'b001000) begin
            st_q.push_back(10); mr_q.push_back(1'b0);
            st_q.push_back(11); mr_q.push_back(1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            check("state_out", 32'(state_out), 32'(exp_state));
            check("controls", 32'(dut_vec()), 32'(exp_out(exp_state, mem_ready, opcode)));
            if (MemRead && MemWrite) check("rd_wr_exclusive", 32'(1), 32'(0));
            if (instr_done) begin
                done_cnt++;
                done_at = cyc;
            end
            cyc++;
        end
    end

    // Runs one instruction; lat is the hand-computed cycle count including stalls.
    task automatic run(input string name, input logic [5:0] op, input int fstall,
                       input int mstall, input int lat);
        build(op, fstall, mstall);
        cyc = 0; done_cnt = 0; done_at = -1;
        opcode = op;
        for (int i = 0; i < st_q.size(); i++) begin
            mem_ready = mr_q[i];
            exp_state = st_q[i];
            exp_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_valid = 1'b0;
        check({name, "_done_count"}, 32'(done_cnt), 32'(1));
        check({name, "_latency"}, 32'(done_at + 1), 32'(lat));
        $display("instr %-6s op=%b stalls=%0d/%0d cycles=%0d done_pulses=%0d",
                 name, op, fstall, mstall, done_at + 1, done_cnt);
    endtask

    initial begin
        rst = 1'b1;
        #1;
        check("reset_state", 32'(state_out), 32'(0));
        check("reset_outputs", 32'(dut_vec()), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        opcode = 6'b000000;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_execute", 32'(state_out), 32'(6));
        check("pre_abort_opalu", 32'(OpALU), 32'(2'b10));
        #1 rst = 1'b1;
        #1;
        check("abort_state", 32'(state_out), 32'(0));
        check("abort_outputs", 32'(dut_vec()), 32'(0));
        @(posedge clk); #1;
        check("held_reset_outputs", 32'(dut_vec()), 32'(0));
        rst = 1'b0;
        #1;
        check("first_fetch_memread", 32'(MemRead), 32'(1));
        check("first_fetch_irwrite", 32'(IRWrite), 32'(1));
        check("first_fetch_pcwrite", 32'(PCWrite), 32'(1));
        check("first_fetch_alusrcb", 32'(ALUSrcB), 32'(2'b01));

        run("RTYPE", 6'b000000, 0, 0, 4);
        run("LW",    6'b100011, 0, 2, 7);
        run("SW",    6'b101011, 0, 0, 4);
        run("BEQ",   6'b000100, 0, 0, 3);
        run("J",     6'b000010, 0, 0, 3);
        run("ILL",   6'b111111, 0, 0, 2);
        run("ADDI",  6'b001000, 0, 0, addi_en() ? 4 : 2);
        run("LW_F",  6'b100011, 1, 0, 6);
        run("SW_S",  6'b101011, 0, 1, 5);
        run("RTYPE", 6'b000000, 2, 0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write strobe, plus the 2-bit OpALU code consumed by the ALU control decoder.
- Stretches memory states with a mem_ready handshake.

Parameters:
- None. The state encoding is fixed; the state_out values below are normative.

Ports:
- clk  in  1  system clock; all state updates occur on the rising edge
- rst  in  1  asynchronous reset, active-high
- opcode  in  6  instruction bits [31:26] from the instruction register; sampled in DECODE and MEMADDR only
- mem_ready  in  1  memory has completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (BEQ)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
- OpALU  out  2  00 = add, 01 = subtract, 10 = decode funct field
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  high during the last cycle of each instruction
- illegal_op  out  1  high for one cycle when DECODE sees an unsupported opcode
- state_out  out  4  current state code, for debug and verification

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-high; asserting it forces the state to FETCH (0) immediately.
  - While rst=1, every output is 0 (strobes are gated by !rst) and state_out=0.
  - The first fetch starts on the first rising edge after rst deasserts.
  - Reset asserted mid-instruction abandons the instruction; no strobe is asserted afterwards.
- Output timing: Moore outputs, decoded combinationally from the registered state. Any output not listed for a state is 0.
- FETCH (0): MemRead=1, ALUSrcB=01, OpALU=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE (1): ALUSrcB=11, OpALU=00 (branch target precompute).
  - opcode 100011 (LW) or 101011 (SW) -> MEMADDR
  - opcode 000000 -> EXECUTE
  - opcode 000100 -> BRANCH
  - opcode 000010 -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 and instr_done=1 this cycle
- MEMADDR (2): ALUSrcA=1, ALUSrcB=10, OpALU=00. LW -> MEMREAD; SW -> MEMWRITE.
- MEMREAD (3): MemRead=1, IorD=1. Stay until mem_ready=1, then -> MEMWB.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 -> FETCH.
- MEMWRITE (5): MemWrite=1, IorD=1. Stay until mem_ready=1; in that cycle instr_done=1, then -> FETCH.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, OpALU=10 -> RCOMPLETE.
- RCOMPLETE (7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
- JUMP (9): PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
- Unused state codes (12-15): recover to FETCH on the next edge with all outputs 0.
- Timing constraints:
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
  - MemRead and MemWrite are never asserted in the same cycle.
- Latency with mem_ready held at 1: LW 5 cycles, SW 4, R-type 4, BEQ 3, J 3.
- Each memory state adds one cycle per cycle that mem_ready is low.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- When defined, opcode 001000 (ADDI) is supported:
  - DECODE -> ADDI_EXEC (10): ALUSrcA=1, ALUSrcB=10, OpALU=00.
  - -> ADDI_WB (11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
  - -> FETCH. ADDI takes 4 cycles.
- When undefined, 001000 is treated as illegal, and codes 10 and 11 are unused state codes.

Test Plan:
- Reset and first fetch: assert rst mid-EXECUTE -> all outputs 0 and state_out=0 at once. Release rst with mem_ready=1 -> first cycle shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type: opcode=000000, mem_ready=1 -> state_out sequence 0,1,6,7,0. OpALU=10 in state 6. RegWrite=1 and RegDst=1 only in state 7. instr_done=1 exactly once.
- LW with stall: opcode=100011, mem_ready low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0. IorD=1 throughout state 3. MemtoReg=1 and RegWrite=1 in state 4.
- SW then BEQ: opcode=101011 -> 0,1,2,5,0 with MemWrite=1 only in state 5. Then opcode=000100 -> 0,1,8,0 with OpALU=01, PCWriteCond=1, PCSource=01 in state 8.
- J and illegal opcode: opcode=000010 -> 0,1,9,0 with PCWrite=1, PCSource=10 in state 9. opcode=111111 -> 0,1,0 with illegal_op=1 for one cycle in state 1 and no RegWrite/MemWrite.
- ADDI: opcode=001000 with MULTICYCLE_ADDI_EN defined -> 0,1,10,11,0 with RegWrite=1, RegDst=0 in state 11. Same stimulus with the macro undefined -> illegal_op=1 in state 1.
